uart_tx_fifo: RTL

//   Parametrised UART transmitter, successor to the single-word TX. Adds a

---
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO, with optional even/odd parity and 1 or 2 stop bits.
// Frames leave back-to-back while the FIFO holds data; the serial line is registered.
module uart_tx_fifo #(
  parameter int CLKRATE     = 100000000,
  parameter int BAUD        = 115200,
  parameter int WORD_LENGTH = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_LENGTH-1:0]        tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          UART_TX
);

  localparam int BAUD_DIV = CLKRATE / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(WORD_LENGTH - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLKRATE/BAUD must be >= 2");
  end
  if (WORD_LENGTH < 5 || WORD_LENGTH > 9) begin : g_bad_word
    $error("uart_tx_fifo: WORD_LENGTH must be 5..9");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   line_q, line_d;

  logic [WORD_LENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic [WORD_LENGTH-1:0] head;
  logic                   push, pop, empty, full, tick;

  function automatic logic parity_of(input logic [WORD_LENGTH-1:0] w);
    return (PARITY == 2) ? ~^w : ^w;
  endfunction

  assign head          = mem_q[rd_ptr_q];
  assign empty         = (count_q == '0);
  assign full          = (count_q == FULL_CNT);
  assign tx_data_ready = ~rst & ~full;
  assign push          = tx_data_valid & tx_data_ready;
  assign tick          = (baud_q == BAUD_LAST);
  assign fifo_count    = count_q;
  assign tx_busy       = (state_q != S_IDLE) | ~empty;
  assign UART_TX       = line_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    line_d  = 1'b1;
    pop     = 1'b0;
    if (state_q != S_IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        pop    = ~empty;
      end
      S_START: begin
        line_d = 1'b0;
        if (tick) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        line_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 4'd1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        line_d = par_q;
        if (tick) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            pop     = ~empty;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop always starts a fresh frame, from IDLE or straight out of STOP.
    if (pop) begin
      shift_d = head;
      par_d   = parity_of(head);
      baud_d  = '0;
      bit_d   = '0;
      state_d = S_START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule
